// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: tracker entry, bubble and select width.
package hazard_pkg;

   // Widest register index any instance may use; narrower indices are zero-extended.
   localparam int MAX_REG_W = 8;

   typedef struct packed {
      logic                 valid;
      logic [MAX_REG_W-1:0] dest;
      logic                 wb_en;
      logic                 ld;
   } entry_t;

   localparam entry_t BUBBLE = '{valid: 1'b0, dest: '0, wb_en: 1'b0, ld: 1'b0};

   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Compares one ID source against every tracked entry; reports matches,
// the youngest usable forwarding select and whether a load result is still too young.
module hazard_src_match
   import hazard_pkg::*;
#(
   parameter int REG_W    = 4,
   parameter int DEPTH    = 2,
   parameter int LOAD_LAT = 1,
   parameter int SEL_W    = sel_width(DEPTH)
) (
   input  entry_t [DEPTH-1:0] entries,
   input  logic [REG_W-1:0]   src_idx,
   input  logic               src_used,
   output logic [DEPTH-1:0]   match_vec,
   output logic [SEL_W-1:0]   sel,
   output logic               load_stall
);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
         assign match_vec[gi] = src_used && entries[gi].valid && entries[gi].wb_en &&
                                (entries[gi].dest == MAX_REG_W'(src_idx));
      end
   endgenerate

   // Scan oldest to youngest so the lowest matching index is the one that sticks.
   always_comb begin
      sel        = '0;
      load_stall = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match_vec[i]) begin
            sel        = SEL_W'(i + 1);
            load_stall = entries[i].ld && (i < LOAD_LAT);
         end
      end
      if (load_stall) begin
         sel = '0;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: in-flight write tracker, stall and forwarding selects.
// Optional stall counter output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int  REG_W    = 4,
   parameter int  NUM_SRC  = 2,
   parameter int  DEPTH    = 2,
   parameter int  LOAD_LAT = 1,
   localparam int SEL_W    = sel_width(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [NUM_SRC*REG_W-1:0] src,
   input  logic [NUM_SRC-1:0]       src_used,
   input  logic [REG_W-1:0]         id_dest,
   input  logic                     id_wb_en,
   input  logic                     id_mem_r_en,
   input  logic                     fwd_en,
   input  logic                     freeze,
   input  logic                     flush,
   output logic                     hazard,
   output logic                     issue,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0]              stall_cnt
`endif
);

   entry_t [DEPTH-1:0] entries_reg;
   entry_t             entry_next;

   logic [NUM_SRC-1:0][DEPTH-1:0] src_match;
   logic [NUM_SRC-1:0][SEL_W-1:0] src_sel;
   logic [NUM_SRC-1:0]            src_load_stall;
   logic                          any_match;
   logic                          any_load_stall;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         hazard_src_match #(
            .REG_W   (REG_W),
            .DEPTH   (DEPTH),
            .LOAD_LAT(LOAD_LAT),
            .SEL_W   (SEL_W)
         ) u_match (
            .entries   (entries_reg),
            .src_idx   (src[gi*REG_W +: REG_W]),
            .src_used  (src_used[gi]),
            .match_vec (src_match[gi]),
            .sel       (src_sel[gi]),
            .load_stall(src_load_stall[gi])
         );
      end
   endgenerate

   assign any_match      = |src_match;
   assign any_load_stall = |src_load_stall;

   // Without forwarding every pending write stalls; with it only a too-young load does.
   assign hazard  = id_valid && (fwd_en ? any_load_stall : any_match);
   assign issue   = id_valid && !hazard && !flush && !freeze;
   assign fwd_sel = (id_valid && fwd_en) ? src_sel : '0;

   always_comb begin
      entry_next = BUBBLE;
      if (issue) begin
         entry_next.valid = 1'b1;
         entry_next.dest  = MAX_REG_W'(id_dest);
         entry_next.wb_en = id_wb_en;
         entry_next.ld    = id_mem_r_en;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_reg[i] <= BUBBLE;
         end
      end else if (!freeze) begin
         entries_reg[0] <= entry_next;
         for (int i = 1; i < DEPTH; i++) begin
            entries_reg[i] <= entries_reg[i-1];
         end
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt_reg;

   // Frozen cycles are memory waits, not hazard stalls, so they are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if (hazard && !freeze && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters; expectations queued per step.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [7:0] src;
   logic [1:0] src_used;
   logic [3:0] id_dest;
   logic       id_wb_en;
   logic       id_mem_r_en;
   logic       fwd_en;
   logic       freeze;
   logic       flush;
   logic       hazard;
   logic       issue;
   logic [3:0] fwd_sel;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] exp_cnt = 32'd0;
`endif

   typedef struct {
      int         tag;
      logic       hz;
      logic       iss;
      logic [3:0] sel;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .src        (src),
      .src_used   (src_used),
      .id_dest    (id_dest),
      .id_wb_en   (id_wb_en),
      .id_mem_r_en(id_mem_r_en),
      .fwd_en     (fwd_en),
      .freeze     (freeze),
      .flush      (flush),
      .hazard     (hazard),
      .issue      (issue),
      .fwd_sel    (fwd_sel)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   // One cycle: drive ID inputs, queue the expected outputs, compare on the falling edge.
   task automatic step(input int tag, input logic r, input logic v,
                       input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used,
                       input logic [3:0] d, input logic wb, input logic ld,
                       input logic fe, input logic fz, input logic fl,
                       input logic e_hz, input logic e_iss, input logic [3:0] e_sel);
      exp_t e;
      rst = r; id_valid = v; src = {s1, s0}; src_used = used;
      id_dest = d; id_wb_en = wb; id_mem_r_en = ld;
      fwd_en = fe; freeze = fz; flush = fl;
      exp_q.push_back('{tag: tag, hz: e_hz, iss: e_iss, sel: e_sel});
      @(negedge clk);
      e = exp_q.pop_front();
      $display("step %0d: hazard=%0b issue=%0b fwd_sel=%b (expected %0b %0b %b)",
               e.tag, hazard, issue, fwd_sel, e.hz, e.iss, e.sel);
      checks++;
      assert (hazard === e.hz) else begin
         errors++;
         $error("FAIL step %0d hazard: observed %0b expected %0b", e.tag, hazard, e.hz);
      end
      checks++;
      assert (issue === e.iss) else begin
         errors++;
         $error("FAIL step %0d issue: observed %0b expected %0b", e.tag, issue, e.iss);
      end
      checks++;
      assert (fwd_sel === e.sel) else begin
         errors++;
         $error("FAIL step %0d fwd_sel: observed %b expected %b", e.tag, fwd_sel, e.sel);
      end
`ifdef HAZARD_STALL_CNT_EN
      checks++;
      assert (stall_cnt === exp_cnt) else begin
         errors++;
         $error("FAIL step %0d stall_cnt: observed %0d expected %0d", e.tag, stall_cnt, exp_cnt);
      end
      if (r) exp_cnt = 32'd0;
      else if (e_hz && !fz && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; src = '0; src_used = '0;
      id_dest = '0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
      fwd_en = 1'b1; freeze = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      //   tag r v  s0 s1 used   d  wb ld fe fz fl  hz iss sel
      step( 0, 1,0, 0, 0, 2'b00, 0, 0,0, 1,0,0,  0,0, 4'b0000);
      step( 1, 0,1, 3, 4, 2'b11, 0, 0,0, 1,0,0,  0,1, 4'b0000);
      // write r5, forwarded from EX then MEM
      step( 2, 0,1, 1, 1, 2'b00, 5, 1,0, 1,0,0,  0,1, 4'b0000);
      step( 3, 0,1, 5, 1, 2'b01, 6, 0,0, 1,0,0,  0,1, 4'b0001);
      step( 4, 0,1, 5, 1, 2'b01, 0, 0,0, 1,0,0,  0,1, 4'b0010);
      // same dependency without forwarding: two stall cycles
      step( 5, 0,1, 1, 1, 2'b00, 5, 1,0, 0,0,0,  0,1, 4'b0000);
      step( 6, 0,1, 5, 1, 2'b01, 8, 1,0, 0,0,0,  1,0, 4'b0000);
      step( 7, 0,1, 5, 1, 2'b01, 8, 1,0, 0,0,0,  1,0, 4'b0000);
      step( 8, 0,1, 5, 1, 2'b01, 8, 1,0, 0,0,0,  0,1, 4'b0000);
      // load r7 then consumer on src1: one stall, then forward from MEM
      step( 9, 0,1, 1, 1, 2'b00, 7, 1,1, 1,0,0,  0,1, 4'b0000);
      step(10, 0,1, 1, 7, 2'b11, 9, 1,0, 1,0,0,  1,0, 4'b0000);
      step(11, 0,1, 1, 7, 2'b11, 9, 1,0, 1,0,0,  0,1, 4'b1000);
      // load r7 again, src1 not read: no stall
      step(12, 0,1, 1, 1, 2'b00, 7, 1,1, 1,0,0,  0,1, 4'b0000);
      step(13, 0,1, 3, 7, 2'b01, 0, 0,0, 1,0,0,  0,1, 4'b0000);
      // r2 written twice: youngest wins, then held by freeze
      step(14, 0,1, 1, 1, 2'b00, 2, 1,0, 1,0,0,  0,1, 4'b0000);
      step(15, 0,1, 1, 1, 2'b00, 2, 1,0, 1,0,0,  0,1, 4'b0000);
      step(16, 0,1, 2, 3, 2'b01,10, 1,0, 1,1,0,  0,0, 4'b0001);
      step(17, 0,1, 2, 3, 2'b01,10, 1,0, 1,1,0,  0,0, 4'b0001);
      step(18, 0,1, 2, 3, 2'b01,10, 1,0, 1,1,0,  0,0, 4'b0001);
      step(19, 0,1, 2, 3, 2'b01,10, 1,0, 1,0,0,  0,1, 4'b0001);
      step(20, 0,1, 2, 3, 2'b01, 0, 0,0, 1,0,0,  0,1, 4'b0010);
      // flush with and without a hazard; flushed write is never tracked
      step(21, 0,1,10, 1, 2'b01, 0, 0,0, 0,0,1,  1,0, 4'b0000);
      step(22, 0,1, 1, 1, 2'b01,11, 1,0, 0,0,1,  0,0, 4'b0000);
      step(23, 0,1,11, 1, 2'b01, 0, 0,0, 0,0,0,  0,1, 4'b0000);
      // invalid ID masks hazard and selects
      step(24, 0,1, 1, 1, 2'b00,12, 1,0, 1,0,0,  0,1, 4'b0000);
      step(25, 0,0,12, 1, 2'b01, 0, 0,0, 1,0,0,  0,0, 4'b0000);
      step(26, 0,1,12, 1, 2'b01, 0, 0,0, 0,0,0,  1,0, 4'b0000);
      // self-dependency, then reset beats freeze
      step(27, 0,1,13, 1, 2'b01,13, 1,0, 0,0,0,  0,1, 4'b0000);
      step(28, 1,1,13, 1, 2'b01, 0, 0,0, 0,1,0,  1,0, 4'b0000);
      step(29, 0,1,13, 1, 2'b01, 0, 0,0, 0,0,0,  0,1, 4'b0000);
      // five hazard cycles, two of them frozen
      step(30, 0,1, 1, 1, 2'b00,14, 1,0, 0,0,0,  0,1, 4'b0000);
      step(31, 0,1,14, 1, 2'b01, 0, 0,0, 0,1,0,  1,0, 4'b0000);
      step(32, 0,1,14, 1, 2'b01, 0, 0,0, 0,1,0,  1,0, 4'b0000);
      step(33, 0,1,14, 1, 2'b01, 0, 0,0, 0,0,0,  1,0, 4'b0000);
      step(34, 0,1,14, 1, 2'b01, 0, 0,0, 0,0,0,  1,0, 4'b0000);
      step(35, 0,1, 1, 1, 2'b00,15, 1,1, 1,0,0,  0,1, 4'b0000);
      step(36, 0,1,15, 1, 2'b01,15, 1,0, 1,0,0,  1,0, 4'b0000);
      step(37, 0,1,15, 1, 2'b01,15, 1,0, 1,0,0,  0,1, 4'b0010);
`ifdef HAZARD_STALL_CNT_EN
      checks++;
      assert (stall_cnt === 32'd3) else begin
         errors++;
         $error("FAIL stall_total: observed %0d expected 3", stall_cnt);
      end
`endif
      // reset pulse clears tracker and counter
      step(38, 1,1,15, 1, 2'b01, 0, 0,0, 0,0,0,  1,0, 4'b0000);
      step(39, 0,1,15, 1, 2'b01, 0, 0,0, 0,0,0,  0,1, 4'b0000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard scoreboard for the ID stage of the pipelined core. It tracks every in-flight register write from EX through the last pre-writeback stage in an internal shift register. It raises `hazard` when an ID-stage source depends on a result that is not yet usable, and reports a per-source forwarding select. Unlike the current single-shot comparator, it supports N sources, configurable pipeline depth and load latency, freeze/flush, and an optional stall counter.

## Interface
- `REG_W`, 4, register index width
- `NUM_SRC`, 2, ID-stage source operands checked
- `DEPTH`, 2, tracked stages (entry 0 = EX, entry 1 = MEM, …), ≥1
- `LOAD_LAT`, 1, entries in which a load result is not yet forwardable, 1 ≤ `LOAD_LAT` ≤ `DEPTH`
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `id_valid`  in  1  ID holds a real instruction
- `src`  in  NUM_SRC*REG_W  packed source indices; source s at bits [s*REG_W +: REG_W]
- `src_used`  in  NUM_SRC  source s is read (generalises two-source flag)
- `id_dest`  in  REG_W  destination of ID instruction
- `id_wb_en`  in  1  ID instruction writes `id_dest`
- `id_mem_r_en`  in  1  ID instruction is a load
- `fwd_en`  in  1  forwarding mode (0 = stall on any dependency)
- `freeze`  in  1  whole pipe held (memory wait)
- `flush`  in  1  ID instruction killed (branch taken)
- `hazard`  out  1  stall ID/IF this cycle
- `issue`  out  1  ID instruction advances into EX this cycle
- `fwd_sel`  out  NUM_SRC*SEL_W  per-source select, SEL_W = clog2(DEPTH+1); 0 = register file, k = entry k-1

## Operation
- Entry = {valid, dest, wb_en, ld}. An entry *matches* source s iff `src_used[s]` and valid and wb_en and dest == src[s].
- `fwd_en`=0: `hazard` = any match in any entry, for any source; `fwd_sel` all 0.
- `fwd_en`=1: for each source, take the youngest matching entry i (lowest index). If it has ld=1 and i < `LOAD_LAT`: `hazard`=1 and that source's `fwd_sel`=0. Otherwise that source's `fwd_sel`=i+1. No match: `fwd_sel`=0. Older matches behind a younger match are ignored.
- `hazard` is qualified by `id_valid`: invalid ID gives `hazard`=0 and `fwd_sel`=0.
- `issue` = `id_valid` & !`hazard` & !`flush` & !`freeze`.
- Shift when !`freeze`: entry[i] ← entry[i-1]; entry[0] ← `issue` ? {1, `id_dest`, `id_wb_en`, `id_mem_r_en`} : bubble (valid=0).
- `freeze`=1: all entries hold. `hazard`/`fwd_sel` are still computed from the held state.
- `flush`=1 with `hazard`=1: a bubble is inserted. `flush` has no effect on entries already issued.

## Timing
- `hazard`, `issue`, `fwd_sel`: combinational from the current entries and ID inputs, same cycle.
- An entry is visible to compares one cycle after `issue`. It leaves the tracker `DEPTH` unfrozen cycles later.
- Load-use with defaults: the consumer stalls exactly 1 cycle with `fwd_en`=1, and 2 cycles with `fwd_en`=0.
- Reset: all entries invalid. With `id_valid`=0: `hazard`=0, `issue`=0, `fwd_sel`=0, `stall_cnt`=0.
- `rst` mid-operation wins over `freeze`/`flush`. All in-flight entries are dropped on the next edge.
- Self-dependency (`id_dest` == own src) is not a hazard.

## Configuration
- `HAZARD_STALL_CNT_EN` defined: adds output `stall_cnt` (out, 32). It increments on every cycle with `hazard`=1 and `freeze`=0, saturates at 0xFFFFFFFF, and resets to 0.
- `HAZARD_STALL_CNT_EN` undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Package `hazard_pkg`: entry struct typedef, bubble constant, SEL_W computation function.
- Sub-module `hazard_src_match`: one source against all entries, producing the match vector, youngest index and stall-needed flag. Instantiated `NUM_SRC` times. Top level holds the shift register, OR-reduction, issue logic and counter.

## Test plan
- After reset, `id_valid`=1, src=(3,4), `src_used`=11 → `hazard`=0, `issue`=1, `fwd_sel`=(0,0).
- Issue write r5 (non-load), next cycle src0=5, `fwd_en`=1 → `hazard`=0, `fwd_sel[0]`=1. Next cycle (entry in MEM) → `fwd_sel[0]`=2.
- Same with `fwd_en`=0 → `hazard`=1 for 2 cycles, then `issue`=1 with `fwd_sel`=0.
- Load r7, then consumer src1=7, `src_used`=11, `fwd_en`=1 → `hazard`=1 for 1 cycle, then `fwd_sel[1]`=2. With `src_used`=01 → no stall.
- Writes r2 then r2 again, consumer src0=2 → `fwd_sel[0]`=1 (youngest wins). Assert `freeze` for 3 cycles → `fwd_sel` is stable and entries do not advance.
- `HAZARD_STALL_CNT_EN` defined: 5 hazard cycles, 2 of them frozen → `stall_cnt`=3. `rst` pulse → `stall_cnt`=0 and `hazard`=0.
